// File: rtl/posit_format_decoder.sv
// posit_format_decoder
// Two-stage valid/ready decoder that unpacks a WIDTH-bit posit into sign,
// signed regime, zero-extended exponent and left-aligned fraction.
// Stage 1 registers the sign, the absolute-value body and the zero/NaR flags.
// Stage 2 finds the regime run and drives the registered output fields.
// Optional feature macro: POSIT_DEC_NAR_STICKY_EN adds the sticky nar_seen output.
module posit_format_decoder #(
    parameter int WIDTH = 7,
    parameter int EN    = 1,
    parameter int W_REG = $clog2(WIDTH) + 1,
    parameter int W_EXP = $clog2(WIDTH) + 1,
    parameter int W_MAN = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] posit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             n_r,
    output logic [W_REG-1:0] regime,
    output logic [W_EXP-1:0] exponent,
    output logic [W_MAN-1:0] mantissa,
    output logic             is_zero,
    output logic             is_nar
`ifdef POSIT_DEC_NAR_STICKY_EN
    ,
    output logic             nar_seen
`endif
);

    // Body is the word without its sign bit; the fraction is what is left
    // of the body after the regime run, terminator and exponent.
    localparam int BW = WIDTH - 1;
    localparam int FW = BW - EN;

    // Length of the run of identical bits starting at the body MSB (1..BW).
    function automatic logic [W_REG-1:0] run_length(input logic [BW-1:0] body);
        logic             done;
        logic [W_REG-1:0] cnt;
        done = 1'b0;
        cnt  = {W_REG{1'b0}};
        for (int i = BW - 1; i >= 0; i--) begin
            if (!done && (body[i] == body[BW-1])) begin
                cnt = cnt + W_REG'(1);
            end else begin
                done = 1'b1;
            end
        end
        return cnt;
    endfunction

    logic             s1_valid_r;
    logic             s1_sign_r;
    logic [BW-1:0]    s1_body_r;
    logic             s1_zero_r;
    logic             s1_nar_r;

    logic             s2_free_s;
    logic             in_ready_s;
    logic [BW-1:0]    abs_body_s;
    logic             raw_zero_s;
    logic             raw_nar_s;

    logic [W_REG-1:0] run_s;
    logic [W_REG-1:0] regime_s;
    logic [BW-1:0]    shifted_s;
    logic [W_EXP-1:0] exp_s;
    logic [W_MAN-1:0] mant_s;

    // Stage 2 can take a word when empty or when its word leaves this cycle.
    assign s2_free_s  = ~out_valid | out_ready;
    assign in_ready_s = ~s1_valid_r | s2_free_s;
    assign in_ready   = in_ready_s;

    // Stage 1 input conditioning: low bits of the two's complement only
    // depend on the low bits, so the body is negated in BW bits.
    always_comb begin
        raw_zero_s = (posit == {WIDTH{1'b0}});
        raw_nar_s  = (posit == {1'b1, {BW{1'b0}}});
        if (posit[WIDTH-1]) begin
            abs_body_s = ~posit[BW-1:0] + BW'(1);
        end else begin
            abs_body_s = posit[BW-1:0];
        end
    end

    // Stage 2 field extraction: drop run plus terminator, then split the rest.
    always_comb begin
        run_s = run_length(s1_body_r);
        if (s1_body_r[BW-1]) begin
            regime_s = run_s - W_REG'(1);
        end else begin
            regime_s = -run_s;
        end
        shifted_s = s1_body_r << (run_s + W_REG'(1));
        if (s1_zero_r | s1_nar_r) begin
            regime_s = {W_REG{1'b0}};
            exp_s    = {W_EXP{1'b0}};
            mant_s   = {W_MAN{1'b0}};
        end else begin
            exp_s  = {{(W_EXP-EN){1'b0}}, shifted_s[BW-1 -: EN]};
            mant_s = {shifted_s[FW-1:0], {(W_MAN-FW){1'b0}}};
        end
    end

    // Stage 1 register: capture sign, absolute body and special flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_body_r  <= {BW{1'b0}};
            s1_zero_r  <= 1'b0;
            s1_nar_r   <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sign_r <= posit[WIDTH-1];
                s1_body_r <= abs_body_s;
                s1_zero_r <= raw_zero_s;
                s1_nar_r  <= raw_nar_s;
            end
        end
    end

    // Stage 2 register: decoded outputs, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            n_r       <= 1'b0;
            regime    <= {W_REG{1'b0}};
            exponent  <= {W_EXP{1'b0}};
            mantissa  <= {W_MAN{1'b0}};
            is_zero   <= 1'b0;
            is_nar    <= 1'b0;
        end else if (s2_free_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                n_r      <= s1_sign_r;
                regime   <= regime_s;
                exponent <= exp_s;
                mantissa <= mant_s;
                is_zero  <= s1_zero_r;
                is_nar   <= s1_nar_r;
            end
        end
    end

`ifdef POSIT_DEC_NAR_STICKY_EN
    // Sticky record that a NaR has been handed downstream since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            nar_seen <= 1'b0;
        end else if (out_valid & out_ready & is_nar) begin
            nar_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_posit_format_decoder.sv
// Directed testbench for posit_format_decoder (WIDTH=7, EN=1).
module tb_posit_format_decoder;

    localparam int WIDTH = 7;
    localparam int W_REG = 4;
    localparam int W_EXP = 4;
    localparam int W_MAN = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] posit;
    logic             out_valid;
    logic             out_ready;
    logic             n_r;
    logic [W_REG-1:0] regime;
    logic [W_EXP-1:0] exponent;
    logic [W_MAN-1:0] mantissa;
    logic             is_zero;
    logic             is_nar;
`ifdef POSIT_DEC_NAR_STICKY_EN
    logic             nar_seen;
    logic             exp_seen;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    posit_format_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .posit     (posit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n_r       (n_r),
        .regime    (regime),
        .exponent  (exponent),
        .mantissa  (mantissa),
        .is_zero   (is_zero),
        .is_nar    (is_nar)
`ifdef POSIT_DEC_NAR_STICKY_EN
        ,
        .nar_seen  (nar_seen)
`endif
    );

    // Count one comparison and report it if it disagrees.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {n_r, regime, exponent, mantissa, is_zero, is_nar} in one word.
    function automatic logic [31:0] pack(input logic s, input logic [3:0] r, input logic [3:0] e,
                                         input logic [6:0] m, input logic z, input logic n);
        return {14'd0, s, r, e, m, z, n};
    endfunction

    function automatic logic [31:0] dut_fields();
        return pack(n_r, regime, exponent, mantissa, is_zero, is_nar);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0]  v_posit [9];
    logic [31:0] v_exp   [9];
    logic [31:0] f_2d;
    logic [31:0] f_0b;
    logic [31:0] f_3f;

    initial begin
        // Hand-decoded vectors.
        v_posit[0] = 7'h2D; v_exp[0] = pack(1'b0, 4'h0, 4'h1, 7'b1010000, 1'b0, 1'b0);
        v_posit[1] = 7'h53; v_exp[1] = pack(1'b1, 4'h0, 4'h1, 7'b1010000, 1'b0, 1'b0);
        v_posit[2] = 7'h0B; v_exp[2] = pack(1'b0, 4'hE, 4'h0, 7'b1100000, 1'b0, 1'b0);
        v_posit[3] = 7'h3F; v_exp[3] = pack(1'b0, 4'h5, 4'h0, 7'b0000000, 1'b0, 1'b0);
        v_posit[4] = 7'h01; v_exp[4] = pack(1'b0, 4'hB, 4'h0, 7'b0000000, 1'b0, 1'b0);
        v_posit[5] = 7'h17; v_exp[5] = pack(1'b0, 4'hF, 4'h0, 7'b1110000, 1'b0, 1'b0);
        v_posit[6] = 7'h7F; v_exp[6] = pack(1'b1, 4'hB, 4'h0, 7'b0000000, 1'b0, 1'b0);
        v_posit[7] = 7'h00; v_exp[7] = pack(1'b0, 4'h0, 4'h0, 7'b0000000, 1'b1, 1'b0);
        v_posit[8] = 7'h40; v_exp[8] = pack(1'b1, 4'h0, 4'h0, 7'b0000000, 1'b0, 1'b1);
        f_2d = v_exp[0];
        f_0b = v_exp[2];
        f_3f = v_exp[3];
`ifdef POSIT_DEC_NAR_STICKY_EN
        exp_seen = 1'b0;
`endif

        // Reset state.
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; posit = 7'h00;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_fields", dut_fields(), 32'd0);
`ifdef POSIT_DEC_NAR_STICKY_EN
        check_val("rst_nar_seen", {31'd0, nar_seen}, 32'd0);
`endif

        // Single words with out_ready high: two-cycle latency, then drain.
        for (int i = 0; i < 9; i++) begin
            posit = v_posit[i]; in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            check_val($sformatf("v%0d_lat1", i), {31'd0, out_valid}, 32'd0);
            tick();
            check_val($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check_val($sformatf("v%0d_fields", i), dut_fields(), v_exp[i]);
            tick();
            check_val($sformatf("v%0d_drain", i), {31'd0, out_valid}, 32'd0);
`ifdef POSIT_DEC_NAR_STICKY_EN
            if (v_posit[i] == 7'h40) exp_seen = 1'b1;
            check_val($sformatf("v%0d_nar_seen", i), {31'd0, nar_seen}, {31'd0, exp_seen});
`endif
        end

        // Backpressure: three words with out_ready low for four edges.
        out_ready = 1'b0;
        posit = 7'h2D; in_valid = 1'b1;
        tick();
        posit = 7'h0B;
        check_val("bp_ready_e1", {31'd0, in_ready}, 32'd1);
        tick();
        posit = 7'h3F;
        check_val("bp_ready_full", {31'd0, in_ready}, 32'd0);
        check_val("bp_valid_e2", {31'd0, out_valid}, 32'd1);
        check_val("bp_hold_e2", dut_fields(), f_2d);
        tick();
        check_val("bp_hold_e3", dut_fields(), f_2d);
        check_val("bp_ready_e3", {31'd0, in_ready}, 32'd0);
        tick();
        check_val("bp_hold_e4", dut_fields(), f_2d);
        check_val("bp_valid_e4", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        #1;
        check_val("bp_ready_comb", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_val("bp_out2_valid", {31'd0, out_valid}, 32'd1);
        check_val("bp_out2", dut_fields(), f_0b);
        tick();
        check_val("bp_out3_valid", {31'd0, out_valid}, 32'd1);
        check_val("bp_out3", dut_fields(), f_3f);
        tick();
        check_val("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset with two words in flight.
        out_ready = 1'b0;
        posit = 7'h2D; in_valid = 1'b1;
        tick();
        posit = 7'h0B;
        tick();
        in_valid = 1'b0;
        check_val("mr_full", {31'd0, out_valid}, 32'd1);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("mr_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("mr_fields", dut_fields(), 32'd0);
`ifdef POSIT_DEC_NAR_STICKY_EN
        check_val("mr_nar_seen", {31'd0, nar_seen}, 32'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("mr_quiet%0d", k), {31'd0, out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/posit_format_decoder.md
Name: posit_format_decoder

Overview:
- Pipelined decoder that unpacks a WIDTH-bit posit word into sign, signed regime, exponent and left-aligned fraction.
- Field format is identical to the one consumed by the posit format encoder, so decode→encode round-trips.
- Sits at the input side of the posit datapath and feeds the arithmetic units.
- Two-stage valid/ready pipeline with full backpressure; zero and NaR are flagged separately.

Parameters:
- WIDTH, 7, posit width in bits including sign.
- EN, 1, exponent field width (es).
- W_REG, $clog2(WIDTH)+1, signed regime output width.
- W_EXP, $clog2(WIDTH)+1, exponent output width.
- W_MAN, WIDTH, fraction output width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  posit word valid.
- in_ready  out  1  decoder can accept this cycle.
- posit  in  WIDTH  posit word.
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  downstream accepts.
- n_r  out  1  sign (1 = negative).
- regime  out  W_REG  signed regime value.
- exponent  out  W_EXP  exponent, zero-extended from EN bits.
- mantissa  out  W_MAN  fraction bits, MSB-first, left-aligned, hidden bit excluded.
- is_zero  out  1  input was all zeros.
- is_nar  out  1  input was 1 followed by all zeros.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- On reset, all stage valids clear. out_valid=0 and all data outputs=0. in_ready=1 from the first cycle after reset.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Stage 1 captures:
  - n_r = posit[WIDTH-1].
  - abs = n_r ? two's complement of posit : posit.
  - is_zero and is_nar, both detected on the raw word.
- Stage 2 decodes and drives the registered outputs:
  - body = abs[WIDTH-2:0]. r0 = body MSB. m = run length of r0 from the MSB, 1..WIDTH-1.
  - regime = r0 ? m-1 : -m.
  - The terminator bit follows the run and is absent when m = WIDTH-1.
  - Exponent is the next EN bits after the terminator. Bits falling past the LSB read as 0.
  - The remaining body bits form the fraction, left-aligned into mantissa with zero fill.
- Special cases: when is_zero or is_nar is set, force regime, exponent and mantissa to 0.
- Latency is exactly 2 cycles from input transfer to out_valid with no stalls. Throughput is 1 word/cycle.
- Stall rule:
  - Stage 2 holds when out_valid & !out_ready.
  - Stage 1 advances when stage 2 is empty or transferring.
  - in_ready = !s1_valid | s1_advance.
- Combinational paths: in_ready depends combinationally on out_ready. No other comb input→output paths.
- While stalled, all outputs hold stable.
- When all stages are full and out_ready rises while a new input is presented, both transfers occur in the same cycle with no bubble.
- rst asserted mid-operation drops in-flight words; no output transfer occurs in that cycle.

Optional Feature:
- Macro: POSIT_DEC_NAR_STICKY_EN.
- When defined:
  - Adds output port nar_seen (1 bit).
  - nar_seen sets on the cycle after any output transfer with is_nar=1 and stays set until rst.
  - Reset value is 0.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic decode, WIDTH=7, EN=1: posit 0x2D, out_ready=1 → 2 cycles later n_r=0, regime=0, exponent=1, mantissa=7'b1010000, flags 0.
- Sign: posit 0x53 → n_r=1, regime=0, exponent=1, mantissa=7'b1010000.
- Negative regime and run extremes:
  - 0x0B → regime=-2, exponent=0, mantissa=7'b1100000.
  - 0x3F → regime=5, exponent=0, mantissa=0.
  - 0x01 → regime=-5, exponent=0, mantissa=0.
- Specials: 0x00 → is_zero=1, fields 0. 0x40 → is_nar=1, fields 0, nar_seen=1 afterward when the macro is defined.
- Backpressure:
  - Stream 0x2D, 0x0B, 0x3F with out_ready held 0 for 4 cycles. in_ready falls once both stages are full, and outputs hold the 0x2D decode.
  - Releasing out_ready delivers all three in order on consecutive cycles.
- Reset mid-flight: assert rst with 2 words in flight → next cycle out_valid=0 and in_ready=1; nothing from before reset emerges.
